fila_leitor: RTL and testbench

- Consumer for the 8-bit queue `fila`: watches the queue occupancy, issues single-cycle `dequeue_in` pulses, captures the popped word and presents it downstream with a valid/ready handshake.
- Each word is held on the output for a minimum number of cycles.
- Sits between `fila` (`len_out`/`data_out` -> this block, `dequeue_out` -> `fila.dequeue_in`) and a slow consumer such as a display driver, all on `clock_10KHz`.

---
 rtl/fila_leitor.sv | 82 ++++++++
 tb/tb_fila_leitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fila_leitor.sv
// rtl/fila_leitor.sv - consumer for the fila queue: pops one word, holds it on a valid/ready output.
module fila_leitor #(
   parameter int DATA_WIDTH  = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clock_10KHz,
   input  logic                  reset,
   input  logic                  enable_in,
   input  logic [7:0]            len_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  ready_in,
   output logic                  dequeue_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [7:0]            count_out
);

   typedef enum logic [1:0] {IDLE, POP, CAPTURE, PRESENT} state_t;

   localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [7:0]            hold_q, hold_d;
   logic [7:0]            count_q, count_d;
   logic                  dequeue_q, dequeue_d;
   logic                  valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      hold_d  = hold_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (enable_in && (len_in != 8'd0)) state_d = POP;
         end
         POP: state_d = CAPTURE;
         CAPTURE: begin
            // fila presents the popped word during this cycle
            data_d  = data_in;
            hold_d  = 8'd0;
            state_d = PRESENT;
         end
         PRESENT: begin
            if (ready_in && (hold_q == HOLD_MAX)) begin
               count_d = count_q + 8'd1;
               state_d = IDLE;
            end else if (hold_q != HOLD_MAX) begin
               hold_d = hold_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      dequeue_d = (state_d == POP);
      valid_d   = (state_d == PRESENT);
   end

   always_ff @(posedge clock_10KHz) begin
      if (reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         hold_q    <= 8'd0;
         count_q   <= 8'd0;
         dequeue_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         hold_q    <= hold_d;
         count_q   <= count_d;
         dequeue_q <= dequeue_d;
         valid_q   <= valid_d;
      end
   end

   assign dequeue_out = dequeue_q;
   assign valid_out   = valid_q;
   assign data_out    = data_q;
   assign count_out   = count_q;

endmodule

// File: tb/tb_fila_leitor.sv
// tb/tb_fila_leitor.sv - directed bench for fila_leitor with a small fila queue model.
module tb_fila_leitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable_in = 1'b0;
   logic [7:0] len_in = 8'd0;
   logic [7:0] data_in = 8'd0;
   logic       ready_in = 1'b0;
   logic       dequeue_out;
   logic [7:0] data_out;
   logic       valid_out;
   logic [7:0] count_out;

   int checks = 0;
   int failures = 0;
   logic [7:0] q[$];

   fila_leitor #(.DATA_WIDTH(8), .HOLD_CYCLES(4)) dut (
      .clock_10KHz(clk),
      .reset(reset),
      .enable_in(enable_in),
      .len_in(len_in),
      .data_in(data_in),
      .ready_in(ready_in),
      .dequeue_out(dequeue_out),
      .data_out(data_out),
      .valid_out(valid_out),
      .count_out(count_out)
   );

   always #5 clk = ~clk;

   // one clock; the queue model pops on an edge where dequeue_out was high
   task automatic tick();
      logic dq;
      dq = dequeue_out;
      @(posedge clk);
      #1;
      if (dq === 1'b1 && q.size() > 0) begin
         data_in = q.pop_front();
         len_in  = 8'(q.size());
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      enable_in = 1'($urandom);
      len_in    = 8'($urandom);
      data_in   = 8'($urandom);
      ready_in  = 1'($urandom);
      do_reset();
      checks++; if (dequeue_out !== 1'b0) begin failures++; $display("FAIL reset_dequeue got=%b exp=0", dequeue_out); end
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
      checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_out); end
      checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
      enable_in = 1'b0;
      len_in    = 8'd0;
   endtask

   task automatic test_drain();
      int pulses = 0, consec = 0, words = 0, unstable = 0;
      logic prev_dq = 1'b0, prev_v = 1'b0;
      logic [7:0] wdata[3];
      int vlen[3] = '{0, 0, 0};
      q = '{8'h00, 8'h01, 8'h02};
      len_in = 8'd3;
      ready_in = 1'b1;
      enable_in = 1'b0;
      do_reset();
      enable_in = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (t == 1) begin
            checks++; if (dequeue_out !== 1'b1) begin failures++; $display("FAIL drain_pop_latency got=%b exp=1", dequeue_out); end
         end
         if (t == 3) begin
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL drain_valid_latency got=%b exp=1", valid_out); end
         end
         if (dequeue_out === 1'b1) begin
            pulses++;
            if (prev_dq) consec++;
         end
         if (valid_out === 1'b1) begin
            if (!prev_v) begin
               if (words < 3) wdata[words] = data_out;
               words++;
            end else if (words <= 3 && data_out !== wdata[words-1]) begin
               unstable++;
            end
            if (words >= 1 && words <= 3) vlen[words-1]++;
         end
         prev_dq = dequeue_out;
         prev_v  = valid_out;
      end
      checks++; if (pulses != 3) begin failures++; $display("FAIL drain_pulses got=%0d exp=3", pulses); end
      checks++; if (consec != 0) begin failures++; $display("FAIL drain_consecutive got=%0d exp=0", consec); end
      checks++; if (words != 3) begin failures++; $display("FAIL drain_words got=%0d exp=3", words); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL drain_stable got=%0d exp=0", unstable); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (wdata[i] !== 8'(i)) begin failures++; $display("FAIL drain_data%0d got=%h exp=%h", i, wdata[i], 8'(i)); end
         checks++; if (vlen[i] != 4) begin failures++; $display("FAIL drain_valid_len%0d got=%0d exp=4", i, vlen[i]); end
      end
      checks++; if (count_out !== 8'd3) begin failures++; $display("FAIL drain_count got=%0d exp=3", count_out); end
      checks++; if (len_in !== 8'd0) begin failures++; $display("FAIL drain_len got=%0d exp=0", len_in); end
      checks++; if (dequeue_out !== 1'b0) begin failures++; $display("FAIL drain_idle_dequeue got=%b exp=0", dequeue_out); end
   endtask

   task automatic test_empty();
      int dq_seen = 0, v_seen = 0;
      q = {};
      len_in = 8'd0;
      enable_in = 1'b1;
      ready_in = 1'b1;
      do_reset();
      for (int t = 0; t < 20; t++) begin
         tick();
         if (dequeue_out !== 1'b0) dq_seen++;
         if (valid_out !== 1'b0) v_seen++;
      end
      checks++; if (dq_seen != 0) begin failures++; $display("FAIL empty_dequeue got=%0d exp=0", dq_seen); end
      checks++; if (v_seen != 0) begin failures++; $display("FAIL empty_valid got=%0d exp=0", v_seen); end
   endtask

   task automatic test_backpressure();
      int bad = 0, n = 0;
      q = '{8'h05, 8'h09};
      len_in = 8'd2;
      enable_in = 1'b1;
      ready_in = 1'b0;
      do_reset();
      while (valid_out !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL bp_reach_present got=%b exp=1", valid_out); end
      enable_in = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (data_out !== 8'h05 || valid_out !== 1'b1 || dequeue_out !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d bad_cycles exp=0", bad); end
      checks++; if (len_in !== 8'd1) begin failures++; $display("FAIL bp_len got=%0d exp=1", len_in); end
      ready_in = 1'b1;
      tick();
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bp_transfer_valid got=%b exp=0", valid_out); end
      checks++; if (count_out !== 8'd1) begin failures++; $display("FAIL bp_count got=%0d exp=1", count_out); end
   endtask

   task automatic test_enable_drop();
      int pops_after = 0;
      q = '{8'h10, 8'h11, 8'h12, 8'h13};
      len_in = 8'd4;
      enable_in = 1'b1;
      ready_in = 1'b1;
      do_reset();
      tick();
      tick();
      enable_in = 1'b0;
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h10) begin failures++; $display("FAIL drop_word got=%b/%h exp=1/10", valid_out, data_out); end
      for (int t = 0; t < 15; t++) begin
         tick();
         if (dequeue_out !== 1'b0) pops_after++;
      end
      checks++; if (count_out !== 8'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", count_out); end
      checks++; if (pops_after != 0) begin failures++; $display("FAIL drop_no_pop got=%0d exp=0", pops_after); end
      checks++; if (len_in !== 8'd3) begin failures++; $display("FAIL drop_len got=%0d exp=3", len_in); end
   endtask

   task automatic test_midop_reset();
      int n = 0;
      q = '{8'h01, 8'h06, 8'h07, 8'h08};
      len_in = 8'd4;
      enable_in = 1'b1;
      ready_in = 1'b1;
      do_reset();
      while (count_out !== 8'd2 && n < 40) begin tick(); n++; end
      ready_in = 1'b0;
      n = 0;
      while (valid_out !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (data_out !== 8'h07 || count_out !== 8'd2) begin failures++; $display("FAIL mid_setup got=%h/%0d exp=07/2", data_out, count_out); end
      do_reset();
      checks++; if ({dequeue_out, valid_out, data_out, count_out} !== 18'd0) begin failures++; $display("FAIL mid_reset_outputs got=%b/%b/%h/%0d exp=0/0/00/0", dequeue_out, valid_out, data_out, count_out); end
      tick();
      checks++; if (dequeue_out !== 1'b1) begin failures++; $display("FAIL mid_restart_pop got=%b exp=1", dequeue_out); end
   endtask

   initial begin
      test_reset();
      test_drain();
      test_empty();
      test_backpressure();
      test_enable_drop();
      test_midop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
